// File: rtl/ap_line_sequencer_pkg.sv
// Shared types for the ApLine command sequencer: command ops, error codes,
// one-hot controller states and small op-classification helpers.
package ap_line_sequencer_pkg;

  typedef enum logic [2:0] {
    OP_NOP      = 3'd0,
    OP_DATA_INC = 3'd1,
    OP_DATA_DEC = 3'd2,
    OP_AP_INC   = 3'd3,
    OP_AP_DEC   = 3'd4,
    OP_DATA_CLR = 3'd5,
    OP_TEST     = 3'd6,
    OP_RESERVED = 3'd7
  } op_e;

  typedef enum logic [1:0] {
    ERR_NONE         = 2'd0,
    ERR_TIMEOUT      = 2'd1,
    ERR_AP_UNDERFLOW = 2'd2,
    ERR_RESERVED_OP  = 2'd3
  } err_e;

  typedef enum logic [5:0] {
    ST_IDLE   = 6'b000001,
    ST_SYNC   = 6'b000010,
    ST_ISSUE  = 6'b000100,
    ST_GUARD  = 6'b001000,
    ST_WAIT   = 6'b010000,
    ST_FINISH = 6'b100000
  } state_e;

  // Ops whose repeat count is honoured.
  function automatic logic op_is_counted(op_e op);
    return op inside {OP_DATA_INC, OP_DATA_DEC, OP_AP_INC, OP_AP_DEC};
  endfunction

  // Ops that step ApLine downwards.
  function automatic logic op_is_dec(op_e op);
    return op inside {OP_DATA_DEC, OP_AP_DEC, OP_DATA_CLR};
  endfunction

  // Ops that move the AP counter rather than the data cell.
  function automatic logic op_is_ap(op_e op);
    return op inside {OP_AP_INC, OP_AP_DEC};
  endfunction

endpackage

// File: rtl/ap_line_step_timer.sv
// Per-step watchdog: down-counter loaded before a step wait, expired at zero.
module ap_line_step_timer #(
  parameter int TO_W = 13
) (
  input  logic            Clk,
  input  logic            Rst_n,
  input  logic            clr_i,
  input  logic            load_i,
  input  logic [TO_W-1:0] load_val_i,
  input  logic            en_i,
  output logic            expired_o
);

  logic [TO_W-1:0] cnt_q, cnt_d;

  // Next count: clear wins over load, decrement holds at zero.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (load_i) begin
      cnt_d = load_val_i;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  // Count register.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (cnt_q == '0);

endmodule

// File: rtl/ap_line_sequencer.sv
// Expands run-length commands into single ApLine step requests, paced on
// ApLine's Ready, with per-step timeout and AP underflow protection.
//
// state  | meaning
// IDLE   | CmdReady high, waiting for a command
// SYNC   | waiting for ApLine Ready, per-op pre-step checks, Dec driven
// ISSUE  | one-cycle ApRequest/DataRequest, IssuedCnt bumped
// GUARD  | ApLine Ready not yet meaningful, ignored
// WAIT   | waiting for step completion under the watchdog
// FINISH | Done and ZeroFlag registered for the following cycle
module ap_line_sequencer
  import ap_line_sequencer_pkg::*;
#(
  parameter int COUNT_W = 8,
  parameter int TIMEOUT = 4096,
  parameter int TO_W    = 13
) (
  input  logic               Clk,
  input  logic               Rst_n,
  input  logic               CmdValid,
  input  logic [2:0]         CmdOp,
  input  logic [COUNT_W-1:0] CmdCount,
  output logic               CmdReady,
  output logic               ApRequest,
  output logic               DataRequest,
  output logic               Dec,
  input  logic               Ready,
  input  logic               DataZero,
  input  logic               ApZero,
  output logic               Done,
  output logic               ZeroFlag,
  output logic [COUNT_W-1:0] IssuedCnt,
  output logic               Err,
  output logic [1:0]         ErrCode
);

  localparam logic [TO_W-1:0] TO_LOAD = TO_W'(TIMEOUT - 1);

  state_e             state_q;
  op_e                op_q;
  logic [COUNT_W-1:0] count_q;
  logic [COUNT_W-1:0] issued_q;
  logic               ap_req_q, data_req_q, dec_q, done_q, zero_q, err_q;
  err_e               err_code_q;
  logic               timer_expired;
  op_e                cmd_op;

  assign cmd_op = op_e'(CmdOp);

  // WAIT lasts at most TIMEOUT cycles: loaded in GUARD, counted in WAIT.
  ap_line_step_timer #(.TO_W(TO_W)) u_step_timer (
    .Clk        (Clk),
    .Rst_n      (Rst_n),
    .clr_i      (!(state_q inside {ST_GUARD, ST_WAIT})),
    .load_i     (state_q == ST_GUARD),
    .load_val_i (TO_LOAD),
    .en_i       (state_q == ST_WAIT),
    .expired_o  (timer_expired)
  );

  // Sequencer FSM with registered outputs.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q    <= ST_IDLE;
      op_q       <= OP_NOP;
      count_q    <= '0;
      issued_q   <= '0;
      ap_req_q   <= 1'b0;
      data_req_q <= 1'b0;
      dec_q      <= 1'b0;
      done_q     <= 1'b0;
      zero_q     <= 1'b0;
      err_q      <= 1'b0;
      err_code_q <= ERR_NONE;
    end else begin
      ap_req_q   <= 1'b0;
      data_req_q <= 1'b0;
      done_q     <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (CmdValid) begin
            op_q       <= cmd_op;
            count_q    <= CmdCount;
            issued_q   <= '0;
            err_q      <= 1'b0;
            err_code_q <= ERR_NONE;
            if (cmd_op == OP_RESERVED) begin
              err_q      <= 1'b1;
              err_code_q <= ERR_RESERVED_OP;
              state_q    <= ST_FINISH;
            end else if (cmd_op == OP_NOP || (op_is_counted(cmd_op) && CmdCount == '0)) begin
              state_q <= ST_FINISH;
            end else begin
              state_q <= ST_SYNC;
            end
          end
        end
        ST_SYNC: begin
          dec_q <= op_is_dec(op_q);
          if (Ready) begin
            if (op_q == OP_TEST || (op_q == OP_DATA_CLR && DataZero)) begin
              state_q <= ST_FINISH;
            end else if (op_q == OP_AP_DEC && ApZero) begin
              err_q      <= 1'b1;
              err_code_q <= ERR_AP_UNDERFLOW;
              state_q    <= ST_FINISH;
            end else begin
              ap_req_q   <= op_is_ap(op_q);
              data_req_q <= !op_is_ap(op_q);
              if (issued_q != '1) begin
                issued_q <= issued_q + 1'b1;
              end
              state_q <= ST_ISSUE;
            end
          end
        end
        ST_ISSUE: state_q <= ST_GUARD;
        ST_GUARD: state_q <= ST_WAIT;
        ST_WAIT: begin
          if (Ready) begin
            // DATA_CLR loops until the cell reads zero; counted ops stop on count.
            if (op_q == OP_DATA_CLR || issued_q != count_q) begin
              state_q <= ST_SYNC;
            end else begin
              state_q <= ST_FINISH;
            end
          end else if (timer_expired) begin
            err_q      <= 1'b1;
            err_code_q <= ERR_TIMEOUT;
            state_q    <= ST_FINISH;
          end
        end
        ST_FINISH: begin
          done_q  <= 1'b1;
          zero_q  <= DataZero;
          dec_q   <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign CmdReady    = (state_q == ST_IDLE);
  assign ApRequest   = ap_req_q;
  assign DataRequest = data_req_q;
  assign Dec         = dec_q;
  assign Done        = done_q;
  assign ZeroFlag    = zero_q;
  assign IssuedCnt   = issued_q;
  assign Err         = err_q;
  assign ErrCode     = err_code_q;

endmodule

// File: tb/tb_ap_line_sequencer.sv
// Bench for ap_line_sequencer: behavioural ApLine model (AP pointer + cell
// array, Ready one cycle late then busy), command-level predictions from
// the model state, and a request protocol monitor.
module tb_ap_line_sequencer;

  localparam int COUNT_W = 8;
  localparam int TIMEOUT = 4096;
  localparam int TO_W    = 13;

  logic               Clk = 1'b0;
  logic               Rst_n;
  logic               CmdValid;
  logic [2:0]         CmdOp;
  logic [COUNT_W-1:0] CmdCount;
  logic               CmdReady, ApRequest, DataRequest, Dec;
  logic               Ready, DataZero, ApZero;
  logic               Done, ZeroFlag, Err;
  logic [COUNT_W-1:0] IssuedCnt;
  logic [1:0]         ErrCode;

  always #5 Clk = ~Clk;

  ap_line_sequencer #(.COUNT_W(COUNT_W), .TIMEOUT(TIMEOUT), .TO_W(TO_W)) dut (
    .Clk(Clk), .Rst_n(Rst_n), .CmdValid(CmdValid), .CmdOp(CmdOp), .CmdCount(CmdCount),
    .CmdReady(CmdReady), .ApRequest(ApRequest), .DataRequest(DataRequest), .Dec(Dec),
    .Ready(Ready), .DataZero(DataZero), .ApZero(ApZero), .Done(Done), .ZeroFlag(ZeroFlag),
    .IssuedCnt(IssuedCnt), .Err(Err), .ErrCode(ErrCode)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always @(posedge Clk) cyc <= cyc + 1;

  // ApLine model: a step is applied on the request edge; Ready stays high one
  // more cycle, then is low for busy_len cycles.
  logic [7:0] m_cells [256];
  logic [7:0] m_ap;
  logic       m_lag, m_stuck, hang_arm;
  int         m_busy, busy_len;

  always @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      for (int i = 0; i < 256; i++) m_cells[i] <= 8'd0;
      m_ap <= 8'd0; m_lag <= 1'b0; m_busy <= 0; m_stuck <= 1'b0;
    end else if (ApRequest || DataRequest) begin
      if (DataRequest) m_cells[m_ap] <= Dec ? m_cells[m_ap] - 8'd1 : m_cells[m_ap] + 8'd1;
      if (ApRequest)   m_ap <= Dec ? m_ap - 8'd1 : m_ap + 8'd1;
      m_lag <= 1'b1; m_busy <= busy_len; m_stuck <= hang_arm;
    end else if (m_lag) begin
      m_lag <= 1'b0;
    end else if (m_busy > 0) begin
      m_busy <= m_busy - 1;
    end
  end

  assign Ready    = m_lag | ((m_busy == 0) & !(m_stuck & hang_arm));
  assign DataZero = (m_cells[m_ap] == 8'd0);
  assign ApZero   = (m_ap == 8'd0);

  // Request monitor: counts pulses and flags protocol violations.
  int   n_ap = 0, n_data = 0, viol = 0;
  int   last_req_cyc = -100, cmd_start_cyc = 0;
  logic exp_dec, prev_req = 1'b0, in_step = 1'b0;

  always @(negedge Clk) begin
    if (!Rst_n) begin
      in_step <= 1'b0; prev_req <= 1'b0;
    end else begin
      if (in_step && !CmdReady && Dec !== exp_dec) viol <= viol + 1;
      if (CmdReady || (Ready && !m_lag)) in_step <= 1'b0;
      if (ApRequest || DataRequest) begin
        if ((ApRequest && DataRequest) || prev_req || Dec !== exp_dec ||
            (last_req_cyc >= cmd_start_cyc && cyc - last_req_cyc < 4)) viol <= viol + 1;
        if (ApRequest)   n_ap   <= n_ap + 1;
        if (DataRequest) n_data <= n_data + 1;
        last_req_cyc <= cyc;
        in_step      <= 1'b1;
      end
      prev_req <= ApRequest || DataRequest;
    end
  end

  task automatic tick();
    @(negedge Clk); #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Issue one command, predict its outcome from the ApLine model state, check.
  task automatic run_cmd(input int op, input int cnt, input bit hang, input string tag);
    int ap0, v, k, fin_ap, fin_v, e_ap, e_data, e_iss, e_code, e_lat;
    int s_ap, s_data, s_viol, acc_cyc, done_cyc;
    logic e_err, e_zero;
    bit seen;
    ap0 = int'(m_ap); v = int'(m_cells[m_ap]);
    fin_ap = ap0; fin_v = v; e_ap = 0; e_data = 0; e_code = 0;
    case (op)
      1: begin e_data = cnt; fin_v = (v + cnt) % 256; end
      2: begin e_data = cnt; fin_v = (v + 512 - cnt) % 256; end
      3: begin e_ap = cnt; fin_ap = (ap0 + cnt) % 256; end
      4: begin e_ap = (cnt > ap0) ? ap0 : cnt; fin_ap = ap0 - e_ap; if (cnt > ap0) e_code = 2; end
      5: begin e_data = v; fin_v = 0; end
      7: e_code = 3;
      default: ;
    endcase
    if (hang) begin e_data = 1; fin_v = (v + 1) % 256; e_code = 1; end
    k      = e_ap + e_data;
    e_iss  = (k > 255) ? 255 : k;
    e_err  = (e_code != 0);
    e_zero = (fin_ap == ap0) ? (fin_v == 0) : (m_cells[fin_ap[7:0]] == 8'd0);
    if (op == 0 || op == 7 || (op >= 1 && op <= 4 && cnt == 0)) e_lat = 2;
    else if (op == 5 || op == 6 || e_code == 2)                e_lat = 3 + k * (4 + busy_len);
    else                                                        e_lat = 2 + k * (4 + busy_len);

    exp_dec = (op == 2 || op == 4 || op == 5);
    s_ap = n_ap; s_data = n_data; s_viol = viol;
    chk({tag, "_cmdready"}, 32'(CmdReady), 32'd1);
    CmdValid = 1'b1; CmdOp = op[2:0]; CmdCount = cnt[COUNT_W-1:0];
    acc_cyc = cyc; cmd_start_cyc = cyc;
    tick();
    CmdValid = 1'b0; CmdOp = 3'($urandom); CmdCount = COUNT_W'($urandom);
    seen = 1'b0; done_cyc = 0;
    for (int i = 0; i < TIMEOUT + 3000; i++) begin
      if (Done) begin seen = 1'b1; done_cyc = cyc; break; end
      tick();
    end
    chk({tag, "_done_seen"}, 32'(seen), 32'd1);
    if (hang) chk({tag, "_timeout_lat"}, done_cyc - last_req_cyc, TIMEOUT + 3);
    else      chk({tag, "_latency"}, done_cyc - acc_cyc, e_lat);
    chk({tag, "_issued"},  32'(IssuedCnt), e_iss);
    chk({tag, "_err"},     32'(Err), 32'(e_err));
    chk({tag, "_errcode"}, 32'(ErrCode), e_code);
    chk({tag, "_zero"},    32'(ZeroFlag), 32'(e_zero));
    chk({tag, "_ap_reqs"},   n_ap - s_ap, e_ap);
    chk({tag, "_data_reqs"}, n_data - s_data, e_data);
    chk({tag, "_protocol"},  viol - s_viol, 0);
    tick();
    chk({tag, "_done_pulse"}, 32'(Done), 32'd0);
    chk({tag, "_err_sticky"}, 32'({Err, ErrCode}), 32'({e_err, e_code[1:0]}));
  endtask

  initial begin
    int  s_ap, s_data, op, cnt;
    bit  got;
    CmdValid = 1'b0; CmdOp = 3'd0; CmdCount = '0;
    hang_arm = 1'b0; busy_len = 1; exp_dec = 1'b0;
    Rst_n = 1'b0;
    repeat (3) tick();
    chk("rst_cmdready", 32'(CmdReady), 32'd1);
    chk("rst_outputs", 32'({ApRequest, DataRequest, Dec, Done, ZeroFlag, Err, ErrCode}), 32'd0);
    chk("rst_issued", 32'(IssuedCnt), 32'd0);
    Rst_n = 1'b1;
    tick();
    chk("post_rst_no_req", 32'({ApRequest, DataRequest}), 32'd0);

    busy_len = 2;
    run_cmd(1, 5, 1'b0, "t1_inc5");
    run_cmd(3, 2, 1'b0, "t2_ap_to2");
    run_cmd(4, 4, 1'b0, "t2_apdec_underflow");
    run_cmd(2, 2, 1'b0, "t3_cell_to3");
    busy_len = 3;
    run_cmd(5, 0, 1'b0, "t3_clr3");
    run_cmd(5, 7, 1'b0, "t3_clr_zero");

    busy_len = 1; hang_arm = 1'b1;
    run_cmd(1, 3, 1'b1, "t4_timeout");
    hang_arm = 1'b0;
    run_cmd(0, 9, 1'b0, "t4_nop_clears_err");

    run_cmd(3, 0, 1'b0, "t5_apinc_zero");
    run_cmd(7, 4, 1'b0, "t5_reserved");
    run_cmd(6, 3, 1'b0, "test_op");

    for (int i = 0; i < 40; i++) begin
      busy_len = $urandom_range(1, 3);
      op  = $urandom_range(0, 7);
      cnt = $urandom_range(0, 6);
      run_cmd(op, cnt, 1'b0, $sformatf("rnd%0d_op%0d", i, op));
    end

    busy_len = 3; exp_dec = 1'b0;
    s_data = n_data;
    CmdValid = 1'b1; CmdOp = 3'd1; CmdCount = COUNT_W'(10); cmd_start_cyc = cyc;
    tick();
    CmdValid = 1'b0;
    got = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (n_data - s_data >= 3) begin got = 1'b1; break; end
      tick();
    end
    chk("t6_reached_step3", 32'(got), 32'd1);
    tick(); tick();
    chk("t6_busy_in_wait", 32'(CmdReady), 32'd0);
    chk("t6_issued_in_wait", 32'(IssuedCnt), 32'd3);
    Rst_n = 1'b0;
    #1;
    chk("t6_rst_cmdready", 32'(CmdReady), 32'd1);
    chk("t6_rst_outputs", 32'({ApRequest, DataRequest, Dec, Done, ZeroFlag, Err, ErrCode}), 32'd0);
    chk("t6_rst_issued", 32'(IssuedCnt), 32'd0);
    tick(); tick();
    Rst_n = 1'b1;
    s_ap = n_ap; s_data = n_data;
    repeat (20) tick();
    chk("t6_no_stray_req", (n_ap - s_ap) + (n_data - s_data), 0);
    chk("t6_idle_after", 32'({CmdReady, Done}), 32'b10);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
